alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; the ALU interface is fixed at 32 bits.
REQ-002 Parameter OPW, default 3, ALU control code width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  out  1  operation N accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands for port N.
REQ-008 req0_op / req1_op  in  OPW  ALU code: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
REQ-009 rsp0_valid / rsp1_valid  out  1  result N available.
REQ-010 rsp0_ready / rsp1_ready  in  1  requester N takes result.
REQ-011 rsp0_result / rsp1_result  out  WIDTH  registered result for port N.
REQ-012 rsp0_zero / rsp1_zero  out  1  registered ALU zero flag (operands equal).
REQ-013 rsp0_err / rsp1_err  out  1  op code was illegal (100, 110, 111).
REQ-014 alu_a, alu_b  out  WIDTH  operands to the shared ALU.
REQ-015 alu_ctrl  out  OPW  control code to the shared ALU.
REQ-016 alu_result  in  WIDTH; alu_zero  in  1  shared ALU outputs.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-019 IDLE: if exactly one reqN_valid, grant N; if both, grant the port not granted last (round-robin); after reset, port 0 has priority.
REQ-020 reqN_ready = (state==IDLE) and granted N; at most one ready per cycle; ready never high outside IDLE.
REQ-021 On valid&&ready, latch a, b, op and grant index; next state EXEC.
REQ-022 EXEC (exactly one cycle): alu_a/alu_b/alu_ctrl driven from latched registers; alu_result and alu_zero captured into response registers of granted port; next state RESP.
REQ-023 Outside EXEC, alu_a, alu_b = 0 and alu_ctrl = 000.
REQ-024 Illegal op: alu_ctrl still driven with latched op; captured result forced to 0, zero forced to 0, err = 1; legal op: err = 0.
REQ-025 RESP: rspN_valid = 1 for granted port only; result/zero/err held stable until rspN_ready.
REQ-026 RESP with rspN_ready = 1: transaction complete, round-robin pointer records N, next state IDLE.
REQ-027 Latency: accept at edge T, rspN_valid high from cycle after edge T+1; minimum 3 cycles per transaction (accept, EXEC, RESP with ready).
REQ-028 Non-granted requester waiting: no ready, its inputs ignored; requester must hold valid and operands stable until ready; valid dropped before ready = no transaction.
REQ-029 rspN_ready while rspN_valid low has no effect.
REQ-030 Starvation bound: with both ports continuously valid, grants strictly alternate 0,1,0,1...

Reset
REQ-031 reset high at any edge: state IDLE, pointer favors port 0, all rsp*_valid/result/zero/err = 0, alu_a/alu_b/alu_ctrl = 0, busy = 0.
REQ-032 Reset mid-EXEC or mid-RESP discards the in-flight transaction; no response is ever presented for it.
REQ-033 reset has priority over every simultaneous handshake.

Verification
REQ-034 Single op: port 0 ADD a=5 b=7, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, result 12, zero 0, err 0.
REQ-035 Contention: both valid after reset, port0 SUB 9-9, port1 SLT 3<4 -> port 0 first (result 0, zero 1), then port 1 (result 1, zero 0); next simultaneous pair grants port 0 again only after port 1 was served.
REQ-036 Backpressure: port 1 OR 0xF0|0x0F with rsp1_ready low 5 cycles -> rsp1_valid high, result 0xFF stable, busy high, req0_ready low throughout.
REQ-037 Illegal op 110 on port 0 -> rsp0_result 0, zero 0, err 1; next legal op clears err.
REQ-038 Reset asserted during RESP -> next cycle all rsp*_valid 0, busy 0; pending requester then accepted normally.
REQ-039 Continuous both-valid for 6 transactions -> grant order 0,1,0,1,0,1, no ready in non-IDLE cycles.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters time-share one external combinational ALU.
//
// One transaction is in flight at a time:
//   IDLE : pick a requester (round-robin on contention) and accept its operands
//   EXEC : drive the shared ALU from the latched operands for exactly one cycle
//          and capture its outputs into the granted port's response registers
//   RESP : present the response until the requester takes it
//
// Handshake rule used on every channel (req0/req1 in, rsp0/rsp1 out): a transfer
// happens on a rising clk edge where valid and ready are both high. The valid side
// holds its payload stable until that edge; ready may depend combinationally on
// valid; a valid withdrawn before the edge means no transfer took place.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation codes the shared ALU understands; every other code is illegal.
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_SLT = OPW'(5);

    state_t           state;

    // Port served most recently; reset value 1 so port 0 wins the first tie.
    logic             last_idx;

    // Latched transaction.
    logic             idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;

    logic             grant_valid;
    logic             grant_idx;
    logic             op_legal;
    logic             rsp_done;

    // Grant selection: only in IDLE; contention resolved against the last served port.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_idx   = ~last_idx;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid && !grant_idx;
    assign req1_ready = grant_valid &&  grant_idx;

    // Decode whether the latched op code is one the ALU implements.
    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    end

    // The granted requester has taken its response this cycle.
    assign rsp_done = (state == RESP) && (idx_q ? rsp1_ready : rsp0_ready);

    // The ALU only sees operands during EXEC; it is driven to zero otherwise.
    assign alu_a    = (state == EXEC) ? a_q  : '0;
    assign alu_b    = (state == EXEC) ? b_q  : '0;
    assign alu_ctrl = (state == EXEC) ? op_q : '0;

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // Transaction sequencing and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_idx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        state    <= IDLE;
                        last_idx <= idx_q;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture the granted requester's operands at the accept handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else if (grant_valid) begin
            idx_q <= grant_idx;
            a_q   <= grant_idx ? req1_a  : req0_a;
            b_q   <= grant_idx ? req1_b  : req0_b;
            op_q  <= grant_idx ? req1_op : req0_op;
        end
    end

    // Response registers: loaded from the ALU in EXEC, cleared when taken.
    // Illegal ops still reach the ALU, but their result and zero flag are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_err    <= 1'b0;
        end else begin
            if (state == EXEC) begin
                if (!idx_q) begin
                    rsp0_valid  <= 1'b1;
                    rsp0_result <= op_legal ? alu_result : '0;
                    rsp0_zero   <= op_legal && alu_zero;
                    rsp0_err    <= !op_legal;
                end else begin
                    rsp1_valid  <= 1'b1;
                    rsp1_result <= op_legal ? alu_result : '0;
                    rsp1_zero   <= op_legal && alu_zero;
                    rsp1_err    <= !op_legal;
                end
            end
            if (rsp_done) begin
                if (!idx_q) begin
                    rsp0_valid <= 1'b0;
                end else begin
                    rsp1_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and randomized checks of the two-port ALU arbiter
// against a transaction-level reference (grant rule, op arithmetic, response timing).
module tb_alu_share_arb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic         rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_zero;
    logic         busy;
    logic [1:0]   fsm_state;

    int total = 0;
    int bad   = 0;
    int last_port;           // port the model says was served last (1 after reset)
    int got;
    logic [33:0] exp_q[$];   // expected {err, zero, result} per accepted transaction

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    alu_share_arb #(.WIDTH(W), .OPW(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .fsm_state(fsm_state)
    );

    // Shared ALU stand-in; illegal codes return garbage so discarding is observable.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'hdead_beef;
        endcase
        alu_zero = (alu_a == alu_b);
    end

    // ---------------- reference model ----------------
    function automatic logic [33:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] r;
        if (op == 3'd4 || op == 3'd6 || op == 3'd7) return {1'b1, 1'b0, 32'd0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd0)      r = 32'(a + b);
        else if (op == 3'd1) r = 32'(a - b);
        else if (op == 3'd2) r = a & b;
        else if (op == 3'd3) r = a | b;
        else                 r = (sa < sb) ? 32'd1 : 32'd0;
        return {1'b0, (a == b), r};
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a, b;
        a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
        b = $urandom_range(0, 3) == 0 ? a : $urandom;
        set_req(p, 3'($urandom_range(0, 7)), a, b);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        last_port = 1;
        exp_q.delete();
    endtask

    // Runs one transaction from the IDLE cycle to completion; called at a negedge.
    task automatic serve(input int stall, output int port);
        int n;
        int exp_g;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [33:0] e;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_in_time", 34'(n < 20), 34'(1));
        if (n >= 20) begin
            port = -1;
            return;
        end
        exp_g = (req0_valid && req1_valid) ? 1 - last_port : (req1_valid ? 1 : 0);
        chk("grant_ready0", 34'(req0_ready), 34'(exp_g == 0));
        chk("grant_ready1", 34'(req1_ready), 34'(exp_g == 1));
        port = exp_g;
        op = (port == 0) ? req0_op : req1_op;
        a  = (port == 0) ? req0_a  : req1_a;
        b  = (port == 0) ? req0_b  : req1_b;
        exp_q.push_back(ref_fn(op, a, b));
        @(negedge clk);
        // EXEC cycle
        chk("exec_busy", 34'(busy), 34'(1));
        chk("exec_no_ready", 34'({req0_ready, req1_ready}), 34'(0));
        chk("exec_alu_a", 34'(alu_a), 34'(a));
        chk("exec_alu_b", 34'(alu_b), 34'(b));
        chk("exec_alu_ctrl", 34'(alu_ctrl), 34'(op));
        chk("exec_no_rsp", 34'({rsp1_valid, rsp0_valid}), 34'(0));
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
        // RESP cycles
        e = exp_q.pop_front();
        for (int i = 0; i <= stall; i++) begin
            chk("rsp_valid", 34'({rsp1_valid, rsp0_valid}), (port == 0) ? 34'(1) : 34'(2));
            chk("rsp_data", (port == 0) ? {rsp0_err, rsp0_zero, rsp0_result}
                                        : {rsp1_err, rsp1_zero, rsp1_result}, e);
            chk("rsp_no_ready", 34'({req0_ready, req1_ready}), 34'(0));
            chk("rsp_busy", 34'(busy), 34'(1));
            chk("rsp_alu_idle", 34'({alu_ctrl, alu_a}), 34'(0));
            // the other port's ready must be ignored while its rsp_valid is low
            if (port == 0) rsp1_ready = 1'($urandom_range(0, 1));
            else           rsp0_ready = 1'($urandom_range(0, 1));
            if (i == stall) begin
                if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        last_port = port;
        chk("done_no_rsp", 34'({rsp1_valid, rsp0_valid}), 34'(0));
        chk("done_idle", 34'(busy), 34'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        last_port = 1;

        // Reset beats a simultaneous request: nothing starts while reset is high.
        @(negedge clk);
        set_req(0, 3'd0, 32'd1, 32'd2);
        repeat (3) begin
            @(negedge clk);
            chk("reset_busy", 34'(busy), 34'(0));
            chk("reset_rsp_valid", 34'({rsp1_valid, rsp0_valid}), 34'(0));
            chk("reset_rsp0", {rsp0_err, rsp0_zero, rsp0_result}, 34'(0));
            chk("reset_rsp1", {rsp1_err, rsp1_zero, rsp1_result}, 34'(0));
            chk("reset_alu", 34'({alu_ctrl, alu_a}), 34'(0));
            chk("reset_alu_b", 34'(alu_b), 34'(0));
        end
        req0_valid = 1'b0;
        do_reset(1);

        // rsp_ready with no response pending does nothing.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        chk("stray_rsp_ready_busy", 34'(busy), 34'(0));
        chk("stray_rsp_ready_valid", 34'({rsp1_valid, rsp0_valid}), 34'(0));

        // Single ADD 5+7 on port 0.
        set_req(0, 3'd0, 32'd5, 32'd7);
        serve(0, got);
        chk("add_port", 34'(got), 34'(0));
        chk("add_result", {rsp0_err, rsp0_zero, rsp0_result}, {2'b00, 32'd12});

        // Contention after reset: port 0 first, then port 1, then port 0 again.
        do_reset(1);
        set_req(0, 3'd1, 32'd9, 32'd9);
        set_req(1, 3'd5, 32'd3, 32'd4);
        serve(0, got);
        chk("cont_first", 34'(got), 34'(0));
        chk("cont_sub", {rsp0_err, rsp0_zero, rsp0_result}, {2'b01, 32'd0});
        serve(1, got);
        chk("cont_second", 34'(got), 34'(1));
        chk("cont_slt", {rsp1_err, rsp1_zero, rsp1_result}, {2'b00, 32'd1});
        set_req(0, 3'd2, 32'hff00, 32'h0ff0);
        set_req(1, 3'd3, 32'h1, 32'h2);
        serve(0, got);
        chk("cont_third", 34'(got), 34'(0));
        req1_valid = 1'b0;

        // Backpressure on port 1 for 5 cycles with port 0 waiting.
        set_req(1, 3'd3, 32'hf0, 32'h0f);
        set_req(0, 3'd0, 32'd1, 32'd1);
        serve(5, got);
        chk("bp_port", 34'(got), 34'(1));
        chk("bp_result", {rsp1_err, rsp1_zero, rsp1_result}, {2'b00, 32'hff});
        serve(0, got);
        chk("bp_waiter", 34'(got), 34'(0));

        // Illegal op 110 (equal operands), then a legal op clears err.
        set_req(0, 3'd6, 32'd7, 32'd7);
        serve(1, got);
        chk("illegal_rsp", {rsp0_err, rsp0_zero, rsp0_result}, {2'b10, 32'd0});
        set_req(0, 3'd0, 32'd3, 32'd3);
        serve(0, got);
        chk("legal_after", {rsp0_err, rsp0_zero, rsp0_result}, {2'b01, 32'd6});

        // Reset during RESP with port 1 waiting.
        set_req(0, 3'd0, 32'd10, 32'd20);
        @(negedge clk);
        req0_valid = 1'b0;
        set_req(1, 3'd1, 32'd50, 32'd8);
        @(negedge clk);
        chk("pre_reset_rsp", 34'(rsp0_valid), 34'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_port = 1;
        exp_q.delete();
        chk("rst_resp_valid", 34'({rsp1_valid, rsp0_valid}), 34'(0));
        chk("rst_resp_busy", 34'(busy), 34'(0));
        serve(0, got);
        chk("rst_resp_next", 34'(got), 34'(1));
        chk("rst_resp_data", {rsp1_err, rsp1_zero, rsp1_result}, {2'b00, 32'd42});

        // Reset during EXEC: that transaction never responds.
        set_req(0, 3'd3, 32'd1, 32'd2);
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_port = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_exec_no_rsp", 34'({rsp1_valid, rsp0_valid}), 34'(0));
            chk("rst_exec_idle", 34'(busy), 34'(0));
        end

        // Continuous contention: grants alternate 0,1,0,1,0,1.
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            if (!req0_valid) rand_req(0);
            if (!req1_valid) rand_req(1);
            serve($urandom_range(0, 2), got);
            chk("alternate", 34'(got), 34'(i % 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) rand_req(0);
            if (!req1_valid && $urandom_range(0, 1) == 1) rand_req(1);
            if (!req0_valid && !req1_valid) rand_req(int'($urandom_range(0, 1)));
            serve($urandom_range(0, 3), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
